// File: rtl/des_chk_pkg.sv
// Shared types and constants for the DES result checker.
package des_chk_pkg;

  localparam int DES_BLK_W = 64;

  typedef enum logic [1:0] {
    CHK_IDLE,
    CHK_RUN,
    CHK_DONE
  } chk_state_e;

endpackage

// File: rtl/chk_sync_fifo.sv
// Single-clock FIFO holding the expected blocks until the matching DUT block arrives.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module chk_sync_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         do_push;
  logic         do_pop;

  // A push is refused while full even if a pop happens in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/des_result_checker.sv
// Verdict producer: buffers expected blocks, compares them in order against the
// DUT output stream, counts matches/mismatches and aborts on a stall.
//
// Handshakes: a block moves on a rising edge where valid & ready are both 1.
// The checker never waits on valid to raise ready, and a source holding valid
// keeps its data stable until the transfer edge.
module des_result_checker
  import des_chk_pkg::*;
#(
  parameter int DATA_W      = DES_BLK_W,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic [DATA_W-1:0] act_data,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  first_err_idx,
  output chk_state_e        dbg_state_o
);

  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYC - 1);
  localparam logic [STALL_W-1:0] STALL_ONE  = 1;
  localparam logic [CNT_W-1:0]   CNT_ONE    = 1;

  chk_state_e         state_q, state_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   match_q, match_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   first_q, first_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               timeout_q, timeout_d;

  logic [DATA_W-1:0]  fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               exp_hs;
  logic               act_hs;
  logic               start_acc;
  logic               fifo_clr;
  logic [CNT_W-1:0]   cmp_idx;

  assign exp_ready = (state_q == CHK_RUN) & ~fifo_full & (acc_q < num_q);
  assign act_ready = (state_q == CHK_RUN) & ~fifo_empty;
  assign exp_hs    = exp_valid & exp_ready;
  assign act_hs    = act_valid & act_ready;
  // Start only re-arms from IDLE or DONE; it also flushes leftover expected blocks.
  assign start_acc = start & (state_q != CHK_RUN);
  assign fifo_clr  = rst | start_acc;
  assign cmp_idx   = match_q + err_q;

  chk_sync_fifo #(
    .W    (DATA_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (fifo_clr),
    .push_i (exp_hs),
    .data_i (exp_data),
    .pop_i  (act_hs),
    .data_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Next-state, counter and compare logic.
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    acc_d     = acc_q;
    match_d   = match_q;
    err_d     = err_q;
    first_d   = first_q;
    stall_d   = stall_q;
    timeout_d = timeout_q;
    case (state_q)
      CHK_IDLE, CHK_DONE: begin
        if (start) begin
          num_d     = num_vec;
          acc_d     = '0;
          match_d   = '0;
          err_d     = '0;
          first_d   = '1;
          stall_d   = '0;
          timeout_d = 1'b0;
          state_d   = (num_vec == '0) ? CHK_DONE : CHK_RUN;
        end
      end
      CHK_RUN: begin
        if (exp_hs) acc_d = acc_q + CNT_ONE;
        if (act_hs) begin
          stall_d = '0;
          if (act_data == fifo_head) begin
            match_d = match_q + CNT_ONE;
          end else begin
            err_d = err_q + CNT_ONE;
            if (err_q == '0) first_d = cmp_idx;
          end
        end else begin
          stall_d = stall_q + STALL_ONE;
        end
        // A finished compare wins over a coincident stall abort.
        if (cmp_idx == num_q) begin
          state_d = CHK_DONE;
        end else if (!act_hs && stall_q == STALL_LAST) begin
          state_d   = CHK_DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = CHK_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CHK_IDLE;
      num_q     <= '0;
      acc_q     <= '0;
      match_q   <= '0;
      err_q     <= '0;
      first_q   <= '1;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      acc_q     <= acc_d;
      match_q   <= match_d;
      err_q     <= err_d;
      first_q   <= first_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  assign done          = (state_q == CHK_DONE);
  assign pass          = done & (err_q == '0) & ~timeout_q;
  assign fail          = done & ~pass;
  assign timeout       = done & timeout_q;
  assign match_cnt     = match_q;
  assign err_cnt       = err_q;
  assign first_err_idx = first_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_des_result_checker.sv
// Bench for des_result_checker: directed runs, a cycle-level reference of the
// observable verdict outputs, and literal checks after each run.
module tb_des_result_checker;
  import des_chk_pkg::*;

  localparam int W     = 64;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int TMO   = 1024;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic             exp_valid;
  logic             exp_ready;
  logic [W-1:0]     exp_data;
  logic             act_valid;
  logic             act_ready;
  logic [W-1:0]     act_data;
  logic             done, pass, fail, timeout;
  logic [CNT_W-1:0] match_cnt, err_cnt, first_err_idx;
  chk_state_e       dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  des_result_checker #(
    .DATA_W(W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .match_cnt(match_cnt), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
    .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] blk(input int tag, input int i);
    int mix;
    mix = i * 32'h0101_0101;
    return {16'hDE5C, tag[7:0], i[7:0], 32'h1234_5678 ^ mix[31:0]};
  endfunction

  // ---------------- scoreboard / reference ----------------
  logic [W-1:0]     exp_q[$];
  int               m_num = 0, m_acc = 0, m_match = 0, m_err = 0, m_stall = 0;
  logic [CNT_W-1:0] m_first = '1;
  bit               m_run = 0, m_fin = 0, m_done = 0, m_tmo = 0;
  bit               chk_en = 0;

  // Compare DUT against the reference, then advance the reference by the
  // transfers that the coming rising edge will perform.
  always @(negedge clk) begin
    bit           hs_e, hs_a, m_pass;
    logic [W-1:0] front;
    if (chk_en) begin
      m_pass = m_done && (m_err == 0) && !m_tmo;
      check("done",          64'(done),          64'(m_done));
      check("pass",          64'(pass),          64'(m_pass));
      check("fail",          64'(fail),          64'(m_done && !m_pass));
      check("timeout",       64'(timeout),       64'(m_done && m_tmo));
      check("match_cnt",     64'(match_cnt),     64'(m_match));
      check("err_cnt",       64'(err_cnt),       64'(m_err));
      check("first_err_idx", 64'(first_err_idx), 64'(m_first));
      check("exp_ready",     64'(exp_ready),
            64'(m_run && (exp_q.size() < DEPTH) && (m_acc < m_num)));
      check("act_ready",     64'(act_ready),     64'(m_run && (exp_q.size() > 0)));

      hs_e = exp_valid && exp_ready;
      hs_a = act_valid && act_ready;
      if (rst) begin
        m_run = 0; m_fin = 0; m_done = 0; m_tmo = 0;
        m_num = 0; m_acc = 0; m_match = 0; m_err = 0; m_stall = 0;
        m_first = '1;
        exp_q.delete();
      end else if (m_run) begin
        if (hs_a && exp_q.size() > 0) begin
          front = exp_q.pop_front();
          if (front == act_data) m_match++;
          else begin
            if (m_err == 0) m_first = CNT_W'(m_match + m_err);
            m_err++;
          end
        end
        if (hs_e) begin
          exp_q.push_back(exp_data);
          m_acc++;
        end
        if (hs_a) m_stall = 0;
        else m_stall++;
        if (m_match + m_err == m_num) begin
          m_run = 0; m_fin = 1;
        end else if (m_stall == TMO) begin
          m_run = 0; m_done = 1; m_tmo = 1;
        end
      end else if (m_fin) begin
        m_fin = 0; m_done = 1;
      end else if (start) begin
        m_num = int'(num_vec);
        m_acc = 0; m_match = 0; m_err = 0; m_stall = 0;
        m_first = '1; m_tmo = 0;
        m_done = (num_vec == 0);
        m_run  = (num_vec != 0);
        exp_q.delete();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start   = 1'b1;
    num_vec = CNT_W'(n);
    tick();
    start   = 1'b0;
  endtask

  task automatic drive_exp(input int tag, input int n);
    for (int i = 0; i < n; i++) begin
      bit got;
      int cyc;
      got = 0; cyc = 0;
      exp_valid = 1'b1;
      exp_data  = blk(tag, i);
      while (!got && cyc < 2000) begin
        @(negedge clk);
        got = exp_ready;
        cyc++;
      end
      tick();
      check("exp_handshake", 64'(got), 64'(1));
    end
    exp_valid = 1'b0;
  endtask

  task automatic drive_act(input int tag, input int n, input int bad, input int hold);
    act_valid = 1'b0;
    repeat (hold) tick();
    for (int i = 0; i < n; i++) begin
      bit got;
      int cyc;
      got = 0; cyc = 0;
      act_valid = 1'b1;
      act_data  = blk(tag, i) ^ ((i == bad) ? 64'h1 : 64'h0);
      while (!got && cyc < 2000) begin
        @(negedge clk);
        got = act_ready;
        cyc++;
      end
      tick();
      check("act_handshake", 64'(got), 64'(1));
    end
    act_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    check("done_reached", 64'(done), 64'(1));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; num_vec = '0;
    exp_valid = 1'b0; exp_data = '0; act_valid = 1'b0; act_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1;

    // reset state
    @(negedge clk);
    check("rst_done",      64'(done),          64'(0));
    check("rst_pass",      64'(pass),          64'(0));
    check("rst_exp_ready", 64'(exp_ready),     64'(0));
    check("rst_first_idx", 64'(first_err_idx), 64'hFFFF);
    check("rst_state",     64'(dbg_state),     64'(CHK_IDLE));
    tick();

    // 1: four identical blocks
    do_start(4);
    fork
      drive_exp(1, 4);
      drive_act(1, 4, -1, 0);
    join
    wait_done(50);
    check("t1_pass",  64'(pass),          64'(1));
    check("t1_match", 64'(match_cnt),     64'(4));
    check("t1_err",   64'(err_cnt),       64'(0));
    check("t1_first", 64'(first_err_idx), 64'hFFFF);
    tick();

    // 2: block 1 corrupted
    do_start(3);
    fork
      drive_exp(2, 3);
      drive_act(2, 3, 1, 0);
    join
    wait_done(50);
    check("t2_fail",  64'(fail),          64'(1));
    check("t2_pass",  64'(pass),          64'(0));
    check("t2_err",   64'(err_cnt),       64'(1));
    check("t2_match", 64'(match_cnt),     64'(2));
    check("t2_first", 64'(first_err_idx), 64'(1));
    tick();

    // 3: DUT stream never arrives
    do_start(2);
    drive_exp(3, 2);
    wait_done(TMO + 50);
    check("t3_timeout", 64'(timeout),   64'(1));
    check("t3_fail",    64'(fail),      64'(1));
    check("t3_match",   64'(match_cnt), 64'(0));
    tick();

    // 4: act stalled until FIFO is full
    do_start(DEPTH + 4);
    fork
      drive_exp(4, DEPTH + 4);
      drive_act(4, DEPTH + 4, -1, 30);
      begin
        repeat (25) tick();
        @(negedge clk);
        check("t4_full_ready", 64'(exp_ready), 64'(0));
      end
    join
    wait_done(50);
    check("t4_pass",  64'(pass),      64'(1));
    check("t4_match", 64'(match_cnt), 64'(DEPTH + 4));
    tick();

    // 5: empty run
    do_start(0);
    @(negedge clk);
    check("t5_done",      64'(done),      64'(1));
    check("t5_pass",      64'(pass),      64'(1));
    check("t5_exp_ready", 64'(exp_ready), 64'(0));
    tick();

    // 6: reset after two compares, then a clean single-block run
    do_start(4);
    fork
      drive_exp(6, 2);
      drive_act(6, 2, -1, 0);
    join
    @(negedge clk);
    check("t6_mid_match", 64'(match_cnt), 64'(2));
    tick();
    rst = 1'b1; exp_valid = 1'b1; exp_data = blk(6, 2);
    act_valid = 1'b1; act_data = blk(6, 2);
    tick();
    rst = 1'b0; exp_valid = 1'b0; act_valid = 1'b0;
    @(negedge clk);
    check("t6_rst_match", 64'(match_cnt),     64'(0));
    check("t6_rst_err",   64'(err_cnt),       64'(0));
    check("t6_rst_first", 64'(first_err_idx), 64'hFFFF);
    check("t6_rst_done",  64'(done),          64'(0));
    check("t6_rst_state", 64'(dbg_state),     64'(CHK_IDLE));
    tick();
    do_start(1);
    fork
      drive_exp(7, 1);
      drive_act(7, 1, -1, 0);
    join
    wait_done(50);
    check("t6_pass",  64'(pass),      64'(1));
    check("t6_match", 64'(match_cnt), 64'(1));
    check("t6_err",   64'(err_cnt),   64'(0));
    tick();

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #1_000_000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete, elapsed %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
